gray_tracker: RTL and testbench

Downstream consumer of the 3-bit up-counting Gray counter (Gray sequence 000,001,011,010,110,111,101,100, then wrap; sticky overflow flag). It samples the counter's Gray output and overflow each clock and produces the following:
- registered binary value
- per-step and per-wrap pulses
- step and wrap counters
- sticky fault flag for any transition other than "hold" or "+1 mod 8"

It sits between the counter and any logic that needs binary position or sequence integrity.

---
 rtl/gray_tracker_pkg.sv | 15 +
 rtl/gray_edge_det.sv | 22 ++
 rtl/gray_tracker.sv | 96 +++++++++
 tb/tb_gray_tracker.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_tracker_pkg.sv
// Shared definitions for the Gray counter consumer and its companions.
package gray_tracker_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    // 3-bit Gray to binary conversion
    function automatic logic [2:0] g2b(input logic [2:0] g);
        return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    endfunction

endpackage

// File: rtl/gray_edge_det.sv
// 1-bit rising-edge detector with registered pulse output.
module gray_edge_det (
    input  logic Clk,
    input  logic Reset,
    input  logic D,
    output logic Rise
);

    logic q;

    // Sample input every edge and pulse on a 0->1 change of the sampled value
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q    <= 1'b0;
            Rise <= 1'b0;
        end else begin
            q    <= D;
            Rise <= D & ~q;
        end
    end

endmodule

// File: rtl/gray_tracker.sv
// Tracks a 3-bit up-counting Gray sequence: binary position, step/wrap
// pulses and counters, and a sticky fault for illegal transitions.
module gray_tracker
    import gray_tracker_pkg::*;
#(
    parameter int unsigned STEP_W = 8,
    parameter int unsigned WRAP_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Clr,
    input  logic [2:0]        Gray,
    input  logic              Ovf,
    output logic [2:0]        Bin,
    output logic              Step,
    output logic              Wrap,
    output logic              OvfRise,
    output logic [STEP_W-1:0] Steps,
    output logic [WRAP_W-1:0] Wraps,
    output logic              Err
);

    state_t     state;
    logic [2:0] prev;
    logic [2:0] gray_bin;

    // Binary position of the incoming Gray code
    always_comb begin
        gray_bin = g2b(Gray);
    end

    // Sequence tracking state machine with registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= INIT;
            prev  <= '0;
            Bin   <= '0;
            Step  <= 1'b0;
            Wrap  <= 1'b0;
            Steps <= '0;
            Wraps <= '0;
        end else begin
            Step <= 1'b0;
            Wrap <= 1'b0;
            if (Clr) begin
                state <= INIT;
                prev  <= '0;
                Bin   <= '0;
                Steps <= '0;
                Wraps <= '0;
            end else begin
                case (state)
                    INIT: begin
                        prev  <= Gray;
                        Bin   <= gray_bin;
                        state <= TRACK;
                    end
                    TRACK: begin
                        if (Gray == prev) begin
                            state <= TRACK;
                        end else if (gray_bin == Bin + 3'd1) begin
                            prev  <= Gray;
                            Bin   <= gray_bin;
                            Step  <= 1'b1;
                            Steps <= Steps + STEP_W'(1);
                            if (Bin == 3'd7) begin
                                Wrap <= 1'b1;
                                if (Wraps != '1)
                                    Wraps <= Wraps + WRAP_W'(1);
                            end
                        end else begin
                            state <= FAULT;
                        end
                    end
                    FAULT: begin
                        state <= FAULT;
                    end
                    default: begin
                        state <= INIT;
                    end
                endcase
            end
        end
    end

    assign Err = (state == FAULT);

    // Overflow edge detection runs regardless of tracking state or Clr
    gray_edge_det u_ovf_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .D     (Ovf),
        .Rise  (OvfRise)
    );

endmodule

// File: tb/tb_gray_tracker.sv
// Scoreboard bench for gray_tracker against a position-based reference model.
module tb_gray_tracker;

    localparam int STEP_W = 8;
    localparam int WRAP_W = 2;

    logic              Clk;
    logic              Reset;
    logic              Clr;
    logic [2:0]        Gray;
    logic              Ovf;
    logic [2:0]        Bin;
    logic              Step;
    logic              Wrap;
    logic              OvfRise;
    logic [STEP_W-1:0] Steps;
    logic [WRAP_W-1:0] Wraps;
    logic              Err;

    gray_tracker #(.STEP_W(STEP_W), .WRAP_W(WRAP_W)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Clr     (Clr),
        .Gray    (Gray),
        .Ovf     (Ovf),
        .Bin     (Bin),
        .Step    (Step),
        .Wrap    (Wrap),
        .OvfRise (OvfRise),
        .Steps   (Steps),
        .Wraps   (Wraps),
        .Err     (Err)
    );

    typedef struct {
        int bin;
        bit step;
        bit wrap;
        bit ovfr;
        int steps;
        int wraps;
        bit err;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // The counter's sequence, position i holds the Gray code of value i
    int seq[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    // Reference model state
    bit m_valid;
    bit m_fault;
    int m_pos;
    int m_steps;
    int m_wraps;
    bit m_ovf_prev;
    int cur_g;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic int pos_of(input int g);
        for (int i = 0; i < 8; i++)
            if (seq[i] == g) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_valid    = 0;
        m_fault    = 0;
        m_pos      = 0;
        m_steps    = 0;
        m_wraps    = 0;
        m_ovf_prev = 0;
    endtask

    // One clock edge of the reference behaviour
    task automatic model_edge(input int g, input bit o, input bit c, output exp_t e);
        int p;
        e.step = 0;
        e.wrap = 0;
        e.ovfr = o && !m_ovf_prev;
        m_ovf_prev = o;
        if (c) begin
            m_valid = 0;
            m_fault = 0;
            m_pos   = 0;
            m_steps = 0;
            m_wraps = 0;
        end else if (m_fault) begin
        end else if (!m_valid) begin
            m_pos   = pos_of(g);
            m_valid = 1;
        end else begin
            p = pos_of(g);
            if (p == m_pos) begin
            end else if (p == (m_pos + 1) % 8) begin
                e.step  = 1;
                m_steps = (m_steps + 1) % (1 << STEP_W);
                if (m_pos == 7) begin
                    e.wrap  = 1;
                    m_wraps = (m_wraps + 1 > (1 << WRAP_W) - 1) ? (1 << WRAP_W) - 1 : m_wraps + 1;
                end
                m_pos = p;
            end else begin
                m_fault = 1;
            end
        end
        e.bin   = m_pos;
        e.steps = m_steps;
        e.wraps = m_wraps;
        e.err   = m_fault;
    endtask

    task automatic do_cycle(input int g, input bit o, input bit c);
        exp_t e;
        @(negedge Clk);
        Gray  = 3'(g);
        Ovf   = o;
        Clr   = c;
        cur_g = g;
        model_edge(g, o, c, e);
        sb.push_back(e);
    endtask

    function automatic int next_g(input int g);
        return seq[(pos_of(g) + 1) % 8];
    endfunction

    // Monitor: compare each registered output set against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("bin",     int'(Bin),     e.bin);
                chk("step",    int'(Step),    int'(e.step));
                chk("wrap",    int'(Wrap),    int'(e.wrap));
                chk("ovfrise", int'(OvfRise), int'(e.ovfr));
                chk("steps",   int'(Steps),   e.steps);
                chk("wraps",   int'(Wraps),   e.wraps);
                chk("err",     int'(Err),     int'(e.err));
            end
        end
    end

    initial begin
        bit o;
        int r;
        int g;
        Reset = 1'b1;
        Clr   = 1'b0;
        Gray  = 3'd0;
        Ovf   = 1'b0;
        cur_g = 0;
        model_reset();
        #22;
        chk("reset_bin",   int'(Bin),   0);
        chk("reset_steps", int'(Steps), 0);
        chk("reset_err",   int'(Err),   0);
        Reset = 1'b0;

        // Full sequence from init on 000 through one wrap
        do_cycle(0, 0, 0);
        for (int i = 0; i < 8; i++) do_cycle(next_g(cur_g), 0, 0);

        // Five steps then an asynchronous reset mid-cycle
        do_cycle(0, 0, 1);
        do_cycle(0, 0, 0);
        for (int i = 0; i < 5; i++) do_cycle(next_g(cur_g), 0, 0);
        @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_bin",   int'(Bin),     0);
        chk("async_step",  int'(Step),    0);
        chk("async_wrap",  int'(Wrap),    0);
        chk("async_ovfr",  int'(OvfRise), 0);
        chk("async_steps", int'(Steps),   0);
        chk("async_wraps", int'(Wraps),   0);
        chk("async_err",   int'(Err),     0);
        model_reset();
        Clr = 1'b0;
        Ovf = 1'b0;
        #1;
        Reset = 1'b0;
        // First sample after reset is accepted without a step
        do_cycle(3, 0, 0);
        do_cycle(2, 0, 0);

        // Forward jump from 001 to 110 faults; later changes ignored
        do_cycle(0, 0, 1);
        do_cycle(0, 0, 0);
        do_cycle(1, 0, 0);
        do_cycle(6, 0, 0);
        do_cycle(3, 0, 0);
        do_cycle(1, 0, 0);
        do_cycle(4, 0, 0);
        do_cycle(4, 0, 1);

        // Backward step from 011 to 001 faults
        do_cycle(0, 0, 0);
        do_cycle(1, 0, 0);
        do_cycle(3, 0, 0);
        do_cycle(1, 0, 0);
        do_cycle(1, 0, 0);

        // Hold on 010
        do_cycle(0, 0, 1);
        do_cycle(0, 0, 0);
        do_cycle(1, 0, 0);
        do_cycle(3, 0, 0);
        for (int i = 0; i < 6; i++) do_cycle(2, 0, 0);

        // Five full cycles, Ovf rises with the first wrap, Wraps saturates
        do_cycle(0, 0, 1);
        do_cycle(0, 0, 0);
        o = 0;
        for (int i = 0; i < 40; i++) begin
            g = next_g(cur_g);
            if (g == 0) o = 1;
            do_cycle(g, o, 0);
        end

        // Randomized traffic
        o = 0;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 19) == 0) o = !o;
            if (r < 3)       do_cycle(cur_g, o, 1);
            else if (r < 72) do_cycle(next_g(cur_g), o, 0);
            else if (r < 88) do_cycle(cur_g, o, 0);
            else             do_cycle($urandom_range(0, 7), o, 0);
        end

        @(posedge Clk);
        #3;
        chk("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
